// File: rtl/musk_wb_pkg.sv
// ============================================================================
// Module : musk_wb_pkg
// Brief  : Shared types and constants for the write-back arbiter slice.
//          Holds the arbiter state encoding, the default line and address
//          widths of the writer data port, and a small index-wrap helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package musk_wb_pkg;

  // Default width of one cache line (64 bytes) as seen by the writer.
  localparam int WB_LINE_BITS = 64 * 8;

  // Default byte-address width of the writer.
  localparam int WB_ADDR_W    = 64;

  // Width of the completed-write counter.
  localparam int WB_CNT_W     = 32;

  // Arbiter phases: waiting for a requester, burst in flight, completion handshake.
  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_BUSY = 2'd1,
    WB_ACK  = 2'd2
  } wb_state_e;

  // Add an offset to a requester index and wrap it into 0..n-1.
  // Both operands are expected to be below n, so a single subtraction suffices.
  function automatic int wrap_add(input int base, input int offset, input int n);
    int sum;
    sum = base + offset;
    if (sum >= n) begin
      sum = sum - n;
    end
    return sum;
  endfunction

endpackage

`default_nettype wire

// File: rtl/musk_rr_pick.sv
// ============================================================================
// Module : musk_rr_pick
// Brief  : Combinational round-robin picker. Scans the request vector
//          starting at ptr and moving upward (wrapping), and returns the
//          first requester found plus a valid flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module musk_rr_pick #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [$clog2(NREQ)-1:0] winner,
  output logic                    valid
);

  import musk_wb_pkg::*;

  localparam int IDX_W = $clog2(NREQ);

  int pos;

  // Walk the candidates from furthest to nearest so the requester closest to
  // ptr is the last one written and therefore wins.
  always_comb begin
    winner = '0;
    pos    = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = wrap_add(int'(ptr), k, NREQ);
      if (req[pos]) begin
        winner = IDX_W'(pos);
      end
    end
  end

  // Any pending request means the winner index is meaningful.
  assign valid = |req;

endmodule

`default_nettype wire

// File: rtl/musk_writeback_arbiter.sv
// ============================================================================
// Module : musk_writeback_arbiter
// Brief  : Shares one line writer between NREQ write-back requesters.
//          Round-robin grant, one line in flight at a time. The winner's
//          address and line are latched at grant so the writer sees stable
//          inputs for the whole burst, whatever the requester does meanwhile.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module musk_writeback_arbiter #(
  parameter int NREQ      = 2,
  parameter int LINE_BITS = musk_wb_pkg::WB_LINE_BITS,
  parameter int ADDR_W    = musk_wb_pkg::WB_ADDR_W
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic [NREQ-1:0]           cli_reqcyc,
  input  logic [NREQ*ADDR_W-1:0]    cli_addr,
  input  logic [NREQ*LINE_BITS-1:0] cli_data,
  output logic [NREQ-1:0]           cli_respcyc,

  output logic                      wr_reqcyc,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [LINE_BITS-1:0]      wr_data,
  input  logic                      wr_respcyc,

  output logic                      busy,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic [31:0]               wr_count
);

  import musk_wb_pkg::*;

  localparam int GRANT_W = $clog2(NREQ);

  // --------------------------------------------------------------------------
  // State and storage
  // --------------------------------------------------------------------------
  wb_state_e            state;
  logic [GRANT_W-1:0]   rr_ptr;
  logic [ADDR_W-1:0]    addr_latch;
  logic [LINE_BITS-1:0] data_latch;

  // Per-requester views of the flattened address/data buses.
  logic [ADDR_W-1:0]    addr_arr [NREQ];
  logic [LINE_BITS-1:0] data_arr [NREQ];

  // Picker results and ACK-exit qualifier.
  logic [GRANT_W-1:0]   pick_id;
  logic                 pick_valid;
  logic                 granted_req;
  logic                 ack_exit;
  logic [GRANT_W-1:0]   next_ptr;

  // --------------------------------------------------------------------------
  // Unpack requester buses into indexable arrays
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_arr[i] = cli_addr[i*ADDR_W +: ADDR_W];
    assign data_arr[i] = cli_data[i*LINE_BITS +: LINE_BITS];
  end

  // --------------------------------------------------------------------------
  // Round-robin selection among pending requesters
  // --------------------------------------------------------------------------
  musk_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req    (cli_reqcyc),
    .ptr    (rr_ptr),
    .winner (pick_id),
    .valid  (pick_valid)
  );

  // The ACK phase ends only once the winner has released its request and the
  // writer has dropped respcyc, so the writer is re-armed before the next burst.
  assign granted_req = cli_reqcyc[grant_id];
  assign ack_exit    = !granted_req && !wr_respcyc;

  // The requester after the last winner gets first look next time.
  assign next_ptr    = GRANT_W'(wrap_add(int'(grant_id), 1, NREQ));

  // Writer-side data always comes from the grant-time latches.
  assign wr_addr = addr_latch;
  assign wr_data = data_latch;

  // Completion is shown only to the granted requester, and only while it still
  // holds its request; a requester that gave up never sees a pulse.
  always_comb begin
    cli_respcyc = '0;
    if (state == WB_ACK) begin
      cli_respcyc[grant_id] = cli_reqcyc[grant_id];
    end
  end

  // Arbiter FSM with grant latches, round-robin pointer and completion counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= WB_IDLE;
      rr_ptr     <= '0;
      grant_id   <= '0;
      addr_latch <= '0;
      data_latch <= '0;
      wr_count   <= '0;
      wr_reqcyc  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        WB_IDLE: begin
          // Writer response here is stale or spurious and is ignored.
          if (pick_valid) begin
            addr_latch <= addr_arr[pick_id];
            data_latch <= data_arr[pick_id];
            grant_id   <= pick_id;
            state      <= WB_BUSY;
            wr_reqcyc  <= 1'b1;
            busy       <= 1'b1;
          end
        end

        WB_BUSY: begin
          // The burst finishes even if the winner has dropped its request.
          if (wr_respcyc) begin
            state     <= WB_ACK;
            wr_reqcyc <= 1'b0;
            wr_count  <= wr_count + 32'd1;
          end
        end

        WB_ACK: begin
          if (ack_exit) begin
            state  <= WB_IDLE;
            busy   <= 1'b0;
            rr_ptr <= next_ptr;
          end
        end

        default: begin
          state     <= WB_IDLE;
          wr_reqcyc <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_musk_writeback_arbiter.sv
// ============================================================================
// Module : tb_musk_writeback_arbiter
// Brief  : Randomized self-checking bench for musk_writeback_arbiter with a
//          behavioural writer, behavioural requesters and a transaction-level
//          reference model of the round-robin arbitration.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_musk_writeback_arbiter;

  localparam int NREQ      = 3;
  localparam int LINE_BITS = 512;
  localparam int ADDR_W    = 64;
  localparam int GW        = $clog2(NREQ);
  localparam int CYCLES    = 1600;

  logic                      clk = 1'b0;
  logic                      reset = 1'b0;
  logic [NREQ-1:0]           cli_reqcyc;
  logic [NREQ*ADDR_W-1:0]    cli_addr;
  logic [NREQ*LINE_BITS-1:0] cli_data;
  logic [NREQ-1:0]           cli_respcyc;
  logic                      wr_reqcyc;
  logic [ADDR_W-1:0]         wr_addr;
  logic [LINE_BITS-1:0]      wr_data;
  logic                      wr_respcyc;
  logic                      busy;
  logic [GW-1:0]             grant_id;
  logic [31:0]               wr_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  musk_writeback_arbiter #(
    .NREQ      (NREQ),
    .LINE_BITS (LINE_BITS),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cli_reqcyc  (cli_reqcyc),
    .cli_addr    (cli_addr),
    .cli_data    (cli_data),
    .cli_respcyc (cli_respcyc),
    .wr_reqcyc   (wr_reqcyc),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_respcyc  (wr_respcyc),
    .busy        (busy),
    .grant_id    (grant_id),
    .wr_count    (wr_count)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_val(input string tag, input logic [LINE_BITS-1:0] got,
                           input logic [LINE_BITS-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [LINE_BITS-1:0] rand_line();
    logic [LINE_BITS-1:0] d;
    for (int j = 0; j < LINE_BITS / 32; j++) d[j*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [ADDR_W-1:0] rand_addr();
    logic [ADDR_W-1:0] a;
    a = {$urandom, $urandom};
    a[5:0] = '0;
    return a;
  endfunction

  // ------------------------------------------------------------------------
  // Behavioural requesters and writer
  // ------------------------------------------------------------------------
  int cool [NREQ];
  int lat;
  int hold;

  task automatic new_line(input int i);
    cli_addr[i*ADDR_W +: ADDR_W]       = rand_addr();
    cli_data[i*LINE_BITS +: LINE_BITS] = rand_line();
  endtask

  task automatic drive_cycle();
    for (int i = 0; i < NREQ; i++) begin
      if (cli_reqcyc[i]) begin
        if (cli_respcyc[i]) begin
          cli_reqcyc[i] = 1'b0;
          cool[i] = $urandom_range(1, 3);
        end else if ($urandom_range(0, 31) == 0) begin
          cli_reqcyc[i] = 1'b0;           // give up mid-wait or mid-burst
          cool[i] = 1;
        end else if ($urandom_range(0, 7) == 0) begin
          new_line(i);                    // data churn while pending/granted
        end
      end else if (cool[i] > 0) begin
        cool[i]--;
      end else if ($urandom_range(0, 2) == 0) begin
        cli_reqcyc[i] = 1'b1;
        new_line(i);
      end
    end
    if (wr_respcyc) begin
      if (!wr_reqcyc) begin
        if (hold > 0) hold--;
        else wr_respcyc = 1'b0;
      end
    end else if (wr_reqcyc) begin
      if (lat > 1) lat--;
      else begin
        wr_respcyc = 1'b1;
        hold = $urandom_range(0, 2);
      end
    end else begin
      lat = $urandom_range(1, 8);
      if ($urandom_range(0, 19) == 0) begin
        wr_respcyc = 1'b1;                // spurious response outside a burst
        hold = 0;
      end
    end
  endtask

  // ------------------------------------------------------------------------
  // Transaction-level reference model, evaluated on the falling edge
  // ------------------------------------------------------------------------
  int                        m_ptr = 0;
  int                        m_w = 0;
  logic                      m_active = 1'b0;
  logic                      m_done = 1'b0;
  logic [31:0]               m_count = '0;
  logic [ADDR_W-1:0]         m_addr = '0;
  logic [LINE_BITS-1:0]      m_data = '0;
  logic [NREQ-1:0]           prev_req = '0;
  logic [NREQ*ADDR_W-1:0]    prev_addr = '0;
  logic [NREQ*LINE_BITS-1:0] prev_data = '0;
  logic                      prev_busy = 1'b0;
  logic                      exp_grant;
  logic [NREQ-1:0]           oh;
  int                        w;
  int                        cand;
  logic                      found;

  always @(negedge clk) begin
    if (!reset) begin
      check_val("rst_wr_reqcyc", wr_reqcyc, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_wr_count", wr_count, 0);
      check_val("rst_grant_id", grant_id, 0);
      check_val("rst_cli_respcyc", cli_respcyc, 0);
      check_val("rst_wr_addr", wr_addr, 0);
      check_val("rst_wr_data", wr_data, 0);
      m_ptr = 0; m_count = '0; m_active = 1'b0; m_done = 1'b0;
    end else begin
      check_val("wr_count", wr_count, m_count);
      exp_grant = !prev_busy && (prev_req != '0);
      check_val("grant_start", wr_reqcyc && !prev_busy, exp_grant);
      if (exp_grant) begin
        w = 0; found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
          cand = (m_ptr + k) % NREQ;
          if (prev_req[cand] && !found) begin
            w = cand; found = 1'b1;
          end
        end
        m_w = w;
        m_addr = prev_addr[w*ADDR_W +: ADDR_W];
        m_data = prev_data[w*LINE_BITS +: LINE_BITS];
        check_val("grant_id", grant_id, w);
        check_val("grant_addr", wr_addr, m_addr);
        check_val("grant_data", wr_data, m_data);
        m_ptr = (w + 1) % NREQ;
        m_active = 1'b1;
        m_done = 1'b0;
      end else if (wr_reqcyc) begin
        check_val("burst_addr_stable", wr_addr, m_addr);
        check_val("burst_data_stable", wr_data, m_data);
      end
      check_val("busy", busy, m_active);
      check_val("wr_reqcyc", wr_reqcyc, m_active && !m_done);
      oh = '0;
      oh[m_w] = 1'b1;
      check_val("cli_respcyc", cli_respcyc, m_done ? (cli_reqcyc & oh) : '0);
      if (m_active && !m_done && wr_respcyc) begin
        m_done = 1'b1;
        m_count = m_count + 32'd1;
      end else if (m_done && !cli_reqcyc[m_w] && !wr_respcyc) begin
        m_active = 1'b0;
        m_done = 1'b0;
      end
    end
    prev_req  = cli_reqcyc;
    prev_addr = cli_addr;
    prev_data = cli_data;
    prev_busy = busy;
  end

  // ------------------------------------------------------------------------
  // Stimulus sequence
  // ------------------------------------------------------------------------
  int waited;

  initial begin
    cli_reqcyc = '0;
    cli_addr   = '0;
    cli_data   = '0;
    wr_respcyc = 1'b0;
    lat = 1;
    hold = 0;
    for (int i = 0; i < NREQ; i++) cool[i] = 0;

    // All requesters pending together as reset releases; client 0 carries
    // address 0x1000 and an incrementing byte pattern.
    @(negedge clk);
    #1;
    cli_reqcyc = '1;
    for (int i = 0; i < NREQ; i++) new_line(i);
    cli_addr[0 +: ADDR_W] = 64'h1000;
    for (int b = 0; b < LINE_BITS / 8; b++) cli_data[b*8 +: 8] = 8'(b);
    @(negedge clk);
    #2 reset = 1'b1;

    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      @(posedge clk);
      #1 drive_cycle();
      if (cyc == CYCLES / 2) begin
        // Abort a burst in flight with an asynchronous reset.
        waited = 0;
        while (!(wr_reqcyc && !wr_respcyc) && waited < 100) begin
          @(posedge clk);
          #1 drive_cycle();
          waited++;
        end
        check_val("burst_wait", waited < 100, 1);
        #2 reset = 1'b0;
        #1;
        check_val("async_rst_reqcyc", wr_reqcyc, 0);
        check_val("async_rst_busy", busy, 0);
        check_val("async_rst_count", wr_count, 0);
        wr_respcyc = 1'b0;
        hold = 0;
        @(negedge clk);
        #2 reset = 1'b1;
      end
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
